// File: rtl/code_serializer_pkg.sv
// ---------------------------------------------------------------------------
// code_serializer_pkg
// Shared constants for the combination-lock entry stage.
//   - Default code width, debounce length and guard length. The downstream
//     detector imports the same defaults so both ends agree on code width.
//   - FSM state encodings for the serializer.
// ---------------------------------------------------------------------------
package code_serializer_pkg;

    localparam int CODE_W_DEF          = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int GUARD_BITS_DEF      = 2;

    // Serializer FSM encodings. Any other value recovers to IDLE.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_GUARD = 2'b10;

endpackage

// File: rtl/code_serializer_if.sv
// ---------------------------------------------------------------------------
// code_serializer_if
// Groups the user-facing and detector-facing signals of the serializer.
//   btn_raw    : raw "send" button (bouncing, asynchronous)
//   code_sw    : code switches, CODE_W bits
//   x_out      : serial code bit to the detector
//   busy       : frame (code plus guard) in flight
//   frame_done : one-cycle pulse on the last guard-bit cycle
// Modports: master drives button/switches, slave is the serializer.
// ---------------------------------------------------------------------------
interface code_serializer_if
    import code_serializer_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF
);
    logic              btn_raw;
    logic [CODE_W-1:0] code_sw;
    logic              x_out;
    logic              busy;
    logic              frame_done;

    modport master (
        output btn_raw,
        output code_sw,
        input  x_out,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  btn_raw,
        input  code_sw,
        output x_out,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/code_serializer_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronizes and debounces a raw push-button and emits a single-cycle
// `press` pulse on each accepted 0->1 change of the debounced level.
//   clk     : system clock
//   reset   : asynchronous, active-high reset
//   btn_raw : raw asynchronous button
//   press   : one-cycle pulse, 2+DEBOUNCE_CYCLES clocks after btn_raw is
//             first sampled high (if it stays high)
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    // Counter only has to hold 0..DEBOUNCE_CYCLES-1.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             stable_prev_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive samples disagreeing with the stable level; the
    // DEBOUNCE_CYCLES-th such sample flips the level.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
            cnt_q         <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/code_serializer.sv
// ---------------------------------------------------------------------------
// code_serializer
// Converts the code on the switches into a bit-serial frame on x_out when
// the debounced "send" button is pressed: CODE_W bits MSB-first followed by
// GUARD_BITS forced zeros. x_out idles low between frames.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : code_serializer_if.slave (btn_raw, code_sw in; x_out, busy,
//           frame_done out, all outputs registered)
// ---------------------------------------------------------------------------
module code_serializer
    import code_serializer_pkg::*;
#(
    parameter int CODE_W          = CODE_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int GUARD_BITS      = GUARD_BITS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    code_serializer_if.slave bus
);

    localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int GRD_W = $clog2(GUARD_BITS + 1);

    logic              press;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [CODE_W-1:0] shift_q;
    logic [CODE_W-1:0] shift_d;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_d;
    logic [GRD_W-1:0]  guard_cnt_q;
    logic [GRD_W-1:0]  guard_cnt_d;
    logic              x_out_q;
    logic              x_out_d;
    logic              busy_q;
    logic              busy_d;
    logic              frame_done_q;
    logic              frame_done_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (bus.btn_raw),
        .press   (press)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        guard_cnt_d = guard_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // Presses seen in any other state are simply dropped.
                if (press) begin
                    shift_d     = bus.code_sw;
                    bit_cnt_d   = '0;
                    guard_cnt_d = '0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == BIT_W'(CODE_W - 1)) begin
                    guard_cnt_d = '0;
                    state_d     = ST_GUARD;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shift_d   = shift_q << 1;
                end
            end
            ST_GUARD: begin
                if (guard_cnt_q == GRD_W'(GUARD_BITS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // line up with the state that is current once the edge has passed.
        x_out_d      = (state_d == ST_SHIFT) & shift_d[CODE_W-1];
        busy_d       = (state_d == ST_SHIFT) | (state_d == ST_GUARD);
        frame_done_d = (state_d == ST_GUARD) &
                       (guard_cnt_d == GRD_W'(GUARD_BITS - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            guard_cnt_q  <= '0;
            x_out_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            guard_cnt_q  <= guard_cnt_d;
            x_out_q      <= x_out_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.x_out      = x_out_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_code_serializer.sv
// ---------------------------------------------------------------------------
// tb_code_serializer
// Two serializers share one button/switch stimulus: instance 0 uses the
// nominal 2 guard bits, instance 1 uses 8 guard bits so that a second
// debounced press can land while a frame is still in flight. A frame-level
// reference model predicts x_out/busy/frame_done for every cycle.
// ---------------------------------------------------------------------------
module tb_code_serializer;
    import code_serializer_pkg::*;

    localparam int CW   = 4;
    localparam int DEB  = 4;
    localparam int GB0  = 2;
    localparam int GB1  = 8;
    localparam int MAXC = 4000;
    localparam int PAD  = CW + GB1 + 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    code_serializer_if #(.CODE_W(CW)) bus0 ();
    code_serializer_if #(.CODE_W(CW)) bus1 ();

    code_serializer #(
        .CODE_W (CW), .DEBOUNCE_CYCLES (DEB), .GUARD_BITS (GB0)
    ) dut0 (
        .clk (clk), .reset (reset), .bus (bus0)
    );

    code_serializer #(
        .CODE_W (CW), .DEBOUNCE_CYCLES (DEB), .GUARD_BITS (GB1)
    ) dut1 (
        .clk (clk), .reset (reset), .bus (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: btn/code value seen at each rising edge, predicted
    // outputs after each edge, debounced level, pending frame start.
    bit              hist      [MAXC];
    logic [CW-1:0]   code_hist [MAXC];
    bit              exp_x     [2][MAXC+PAD];
    bit              exp_busy  [2][MAXC+PAD];
    bit              exp_fd    [2][MAXC+PAD];
    bit              stable_m;
    int              pending_s;
    int              last_s    [2];
    int              edge_n;

    logic [31:0]     bits_col    [2];
    int              frames      [2];
    int              busy_cycles [2];
    int              first_busy  [2];

    logic [CW-1:0]   code;
    bit              lvl;
    bit              rst_r;
    int              e0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gb_of(input int i);
        return (i == 0) ? GB0 : GB1;
    endfunction

    // Advance the frame-level model by one rising edge n.
    task automatic model_edge(input int n);
        if (reset) begin
            // Synchronizer flops are cleared, so the last two samples are lost.
            hist[n] = 1'b0;
            if (n > 0) hist[n-1] = 1'b0;
            stable_m  = 1'b0;
            pending_s = -1;
            last_s[0] = -100;
            last_s[1] = -100;
            for (int i = 0; i < 2; i++) begin
                for (int k = n; k < n + PAD; k++) begin
                    exp_x[i][k]    = 1'b0;
                    exp_busy[i][k] = 1'b0;
                    exp_fd[i][k]   = 1'b0;
                end
            end
            return;
        end
        // A press visible before edge n starts a frame at n if idle.
        if (pending_s == n) begin
            pending_s = -1;
            for (int i = 0; i < 2; i++) begin
                int flen;
                flen = CW + gb_of(i);
                if (n >= last_s[i] + flen + 1) begin
                    last_s[i] = n;
                    for (int b = 0; b < CW; b++) exp_x[i][n+b] = code_hist[n][CW-1-b];
                    for (int k = 0; k < flen; k++) exp_busy[i][n+k] = 1'b1;
                    exp_fd[i][n+flen-1] = 1'b1;
                end
            end
        end
        // Debounced level flips once DEB consecutive synchronized samples
        // (two edges old) disagree with it.
        if (n - 1 - DEB >= 0) begin
            bit run;
            run = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (hist[n-2-j] == stable_m) run = 1'b0;
            end
            if (run) begin
                stable_m = ~stable_m;
                if (stable_m) pending_s = n + 2;
            end
        end
    endtask

    task automatic observe(input int i, input logic x, input logic bz, input logic fd);
        check($sformatf("x_out%0d@%0d", i, edge_n), {31'd0, x}, {31'd0, exp_x[i][edge_n]});
        check($sformatf("busy%0d@%0d", i, edge_n), {31'd0, bz}, {31'd0, exp_busy[i][edge_n]});
        check($sformatf("frame_done%0d@%0d", i, edge_n), {31'd0, fd}, {31'd0, exp_fd[i][edge_n]});
        if (bz === 1'b1) begin
            bits_col[i] = {bits_col[i][30:0], x};
            busy_cycles[i]++;
            if (first_busy[i] < 0) first_busy[i] = edge_n;
        end
        if (fd === 1'b1) frames[i]++;
    endtask

    task automatic step(input bit b, input logic [CW-1:0] c, input bit rst);
        @(negedge clk);
        reset        = rst;
        bus0.btn_raw = b;
        bus1.btn_raw = b;
        bus0.code_sw = c;
        bus1.code_sw = c;
        @(posedge clk);
        edge_n++;
        if (edge_n >= MAXC - PAD) begin
            $display("FAIL cycle_budget: edge %0d, limit %0d", edge_n, MAXC - PAD);
            $fatal(1, "cycle budget exhausted");
        end
        hist[edge_n]      = b;
        code_hist[edge_n] = c;
        model_edge(edge_n);
        #1;
        observe(0, bus0.x_out, bus0.busy, bus0.frame_done);
        observe(1, bus1.x_out, bus1.busy, bus1.frame_done);
    endtask

    task automatic run(input bit b, input logic [CW-1:0] c, input bit rst, input int n);
        for (int k = 0; k < n; k++) step(b, c, rst);
    endtask

    task automatic clear_col();
        for (int i = 0; i < 2; i++) begin
            bits_col[i]    = '0;
            frames[i]      = 0;
            busy_cycles[i] = 0;
            first_busy[i]  = -1;
        end
    endtask

    // Assert reset between edges; outputs must drop without waiting for clk.
    task automatic async_reset_now();
        #2 reset = 1'b1;
        #1;
        check("async_rst_x0", {31'd0, bus0.x_out}, 32'd0);
        check("async_rst_busy0", {31'd0, bus0.busy}, 32'd0);
        check("async_rst_fd0", {31'd0, bus0.frame_done}, 32'd0);
        check("async_rst_x1", {31'd0, bus1.x_out}, 32'd0);
        check("async_rst_busy1", {31'd0, bus1.busy}, 32'd0);
    endtask

    initial begin
        edge_n       = -1;
        stable_m     = 1'b0;
        pending_s    = -1;
        last_s[0]    = -100;
        last_s[1]    = -100;
        bus0.btn_raw = 1'b0;
        bus1.btn_raw = 1'b0;
        bus0.code_sw = '0;
        bus1.code_sw = '0;
        clear_col();

        // Reset state
        run(1'b0, 4'b0000, 1'b1, 3);
        run(1'b0, 4'b0000, 1'b0, 4);
        check("reset_busy", {31'd0, bus0.busy}, 32'd0);

        // Send code 0101: press at +6, first bit at +7
        clear_col();
        e0 = edge_n + 1;
        run(1'b1, 4'b0101, 1'b0, 10);
        run(1'b0, 4'b0101, 1'b0, 20);
        check("send_latency", first_busy[0] - e0, 32'd7);
        check("send_bits", {26'd0, bits_col[0][5:0]}, 32'b010100);
        check("send_frames", frames[0], 32'd1);
        check("send_busy_len", busy_cycles[0], 32'd6);

        // Bounce rejection
        clear_col();
        run(1'b1, 4'b0101, 1'b0, 3);
        run(1'b0, 4'b0101, 1'b0, 1);
        run(1'b1, 4'b0101, 1'b0, 2);
        run(1'b0, 4'b0101, 1'b0, 20);
        check("bounce_busy", busy_cycles[0], 32'd0);
        check("bounce_frames", frames[1], 32'd0);

        // Held button: one frame, then a second only after release
        clear_col();
        run(1'b1, 4'b1111, 1'b0, 40);
        run(1'b0, 4'b1111, 1'b0, 20);
        check("held_bits", {26'd0, bits_col[0][5:0]}, 32'b111100);
        check("held_frames", frames[0], 32'd1);
        run(1'b1, 4'b1111, 1'b0, 8);
        run(1'b0, 4'b1111, 1'b0, 20);
        check("repress_frames", frames[0], 32'd2);

        // Busy lockout and switch isolation (long-guard instance)
        clear_col();
        run(1'b1, 4'b1001, 1'b0, 4);
        run(1'b0, 4'b1001, 1'b0, 4);
        run(1'b1, 4'b0110, 1'b0, 4);
        run(1'b0, 4'b0110, 1'b0, 24);
        check("lockout_bits1", {20'd0, bits_col[1][11:0]}, 32'b1001_0000_0000);
        check("lockout_frames1", frames[1], 32'd1);
        check("lockout_bits0", {20'd0, bits_col[0][11:0]}, 32'b100100_011000);
        check("lockout_frames0", frames[0], 32'd2);

        // Press during the final guard cycle is dropped
        clear_col();
        run(1'b1, 4'b1010, 1'b0, 4);
        run(1'b0, 4'b1010, 1'b0, 8);
        run(1'b1, 4'b1010, 1'b0, 4);
        run(1'b0, 4'b1010, 1'b0, 30);
        check("guard_exit_frames1", frames[1], 32'd1);
        check("guard_exit_frames0", frames[0], 32'd2);

        // Reset mid-frame at T+2
        clear_col();
        run(1'b1, 4'b1011, 1'b0, 9);
        check("pre_reset_busy", {31'd0, bus0.busy}, 32'd1);
        async_reset_now();
        run(1'b0, 4'b1011, 1'b1, 2);
        clear_col();
        run(1'b0, 4'b1011, 1'b0, 20);
        check("post_reset_busy0", busy_cycles[0], 32'd0);
        check("post_reset_busy1", busy_cycles[1], 32'd0);
        run(1'b1, 4'b1011, 1'b0, 8);
        run(1'b0, 4'b1011, 1'b0, 20);
        check("post_reset_bits", {26'd0, bits_col[0][5:0]}, 32'b101100);
        check("post_reset_frames", frames[0], 32'd1);

        // Randomized button activity, switch changes and occasional resets
        lvl  = 1'b0;
        code = 4'b0000;
        for (int seg = 0; seg < 120; seg++) begin
            int len;
            len = $urandom_range(1, 14);
            lvl = ~lvl;
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) code = CW'($urandom);
                rst_r = ($urandom_range(0, 299) == 0);
                step(lvl, code, rst_r);
            end
        end
        run(1'b0, code, 1'b0, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
